// File: rtl/transform4x4_pkg.sv
// Shared types and coefficient tables for the 4x4 forward/inverse integer transform engine.
package transform4x4_pkg;

  typedef enum logic [1:0] {IDLE, S1, S2, HOLD} state_e;

  typedef enum logic [2:0] {ZERO, P1, N1, P2, N2, PH, NH} coef_e;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  localparam coef_e FWD_TAB [4][4] = '{
    '{P1, P1, P1, P1},
    '{P2, P1, N1, N2},
    '{P1, N1, N1, P1},
    '{P1, N2, P2, N1}
  };

  localparam coef_e INV_TAB [4][4] = '{
    '{P1, P1, P1, PH},
    '{P1, PH, N1, N1},
    '{P1, NH, N1, P1},
    '{P1, N1, P1, NH}
  };

  function automatic coef_e coef_at(input logic mode, input logic [1:0] row, input logic [1:0] col);
    return (mode == MODE_INV) ? INV_TAB[row][col] : FWD_TAB[row][col];
  endfunction

endpackage

// File: rtl/transform4x4_term.sv
// One scaled operand for the shared adder: x, -x, 2x, -2x, floor(x/2), -floor(x/2) or 0.
module transform4x4_term
  import transform4x4_pkg::*;
#(
  parameter int ACC_W = 15
) (
  input  logic [2:0]              code,
  input  logic signed [ACC_W-1:0] operand,
  output logic signed [ACC_W-1:0] term
);

  always_comb begin
    term = '0;
    case (code)
      P1:      term = operand;
      N1:      term = -operand;
      P2:      term = operand <<< 1;
      N2:      term = -(operand <<< 1);
      PH:      term = operand >>> 1;
      NH:      term = -(operand >>> 1);
      default: term = '0;
    endcase
  end

endmodule

// File: rtl/transform4x4_engine.sv
// 4x4 forward/inverse core transform (T = A*X*A^T) on one time-shared 4-input adder, 32 compute cycles.
// Optional output clamping when TRANSFORM4X4_SATURATE_EN is defined.
module transform4x4_engine
  import transform4x4_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int OUT_W = 15
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [16*IN_W-1:0]    in_X,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*OUT_W-1:0]   out_T,
  output logic                  out_busy
);

  localparam int ACC_W = IN_W + 6;

  state_e                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic                    mode_q, mode_d;
  logic signed [ACC_W-1:0] x_q [16];
  logic signed [ACC_W-1:0] x_d [16];
  logic signed [ACC_W-1:0] m_q [16];
  logic signed [ACC_W-1:0] m_d [16];
  logic signed [OUT_W-1:0] t_q [16];
  logic signed [OUT_W-1:0] t_d [16];

  logic signed [ACC_W-1:0] op_w   [4];
  logic signed [ACC_W-1:0] term_w [4];
  logic [2:0]              code_w [4];
  logic signed [ACC_W-1:0] sum_w;
  logic signed [OUT_W-1:0] res_w;
  logic [1:0]              row_w, col_w;

  assign row_w = idx_q[3:2];
  assign col_w = idx_q[1:0];

  // Pass 1 walks column c of X against row r of A; pass 2 walks row r of M against row c of A.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      op_w[k]   = '0;
      code_w[k] = ZERO;
    end
    case (state_q)
      S1: begin
        for (int k = 0; k < 4; k++) begin
          op_w[k]   = x_q[{2'(k), col_w}];
          code_w[k] = coef_at(mode_q, row_w, 2'(k));
        end
      end
      S2: begin
        for (int k = 0; k < 4; k++) begin
          op_w[k]   = m_q[{row_w, 2'(k)}];
          code_w[k] = coef_at(mode_q, col_w, 2'(k));
        end
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_term
      transform4x4_term #(.ACC_W(ACC_W)) u_term (
        .code    (code_w[gi]),
        .operand (op_w[gi]),
        .term    (term_w[gi])
      );
    end
  endgenerate

  assign sum_w = term_w[0] + term_w[1] + term_w[2] + term_w[3];

  generate
    if (OUT_W >= ACC_W) begin : g_ext
      assign res_w = OUT_W'(sum_w);
    end else begin : g_narrow
`ifdef TRANSFORM4X4_SATURATE_EN
      localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
      localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
      logic signed [ACC_W-1:0] clamp_w;
      always_comb begin
        clamp_w = sum_w;
        if (sum_w > SAT_MAX) begin
          clamp_w = SAT_MAX;
        end else if (sum_w < SAT_MIN) begin
          clamp_w = SAT_MIN;
        end
      end
      assign res_w = OUT_W'(clamp_w);
`else
      assign res_w = OUT_W'(sum_w);
`endif
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    x_d       = x_q;
    m_d       = m_q;
    t_d       = t_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_busy  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          for (int i = 0; i < 16; i++) begin
            x_d[i] = ACC_W'($signed(in_X[i*IN_W +: IN_W]));
          end
          mode_d  = in_mode;
          idx_d   = '0;
          state_d = S1;
        end
      end
      S1: begin
        out_busy   = 1'b1;
        m_d[idx_q] = sum_w;
        idx_d      = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          idx_d   = '0;
          state_d = S2;
        end
      end
      S2: begin
        out_busy   = 1'b1;
        t_d[idx_q] = res_w;
        idx_d      = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          idx_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= MODE_FWD;
      for (int i = 0; i < 16; i++) begin
        x_q[i] <= '0;
        m_q[i] <= '0;
        t_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      m_q     <= m_d;
      t_q     <= t_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_out
      assign out_T[gi*OUT_W +: OUT_W] = t_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_transform4x4_engine.sv
// Directed bench for transform4x4_engine: vector table plus hold, back-pressure and reset sequences.
module tb_transform4x4_engine;

  localparam int IN_W = 9;
  localparam int OUT_W = 15;
  localparam int OW12 = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                a_valid, a_ready, a_mode, a_ovalid, a_oready, a_busy;
  logic [16*IN_W-1:0]  a_X;
  logic [16*OUT_W-1:0] a_T;
  logic                b_valid, b_ready, b_mode, b_ovalid, b_oready, b_busy;
  logic [16*IN_W-1:0]  b_X;
  logic [16*OW12-1:0]  b_T;

  transform4x4_engine #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .in_clk(clk), .in_rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_mode(a_mode),
    .in_X(a_X), .out_valid(a_ovalid), .out_ready(a_oready), .out_T(a_T), .out_busy(a_busy)
  );

  transform4x4_engine #(.IN_W(IN_W), .OUT_W(OW12)) dut12 (
    .in_clk(clk), .in_rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_mode(b_mode),
    .in_X(b_X), .out_valid(b_ovalid), .out_ready(b_oready), .out_T(b_T), .out_busy(b_busy)
  );

  typedef struct packed {
    logic              mode;
    logic [15:0][15:0] x;
    logic [15:0][15:0] e;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int a_t(input int j);
    return int'($signed(a_T[j*OUT_W +: OUT_W]));
  endfunction

  function automatic int b_t(input int j);
    return int'($signed(b_T[j*OW12 +: OW12]));
  endfunction

  task automatic fill(input int v, input logic mode, input int xall, input int xidx, input int xval);
    vecs[v].mode = mode;
    for (int j = 0; j < 16; j++) begin
      vecs[v].x[j] = 16'(xall);
      vecs[v].e[j] = '0;
    end
    if (xidx >= 0) vecs[v].x[xidx] = 16'(xval);
  endtask

  task automatic set_row(input int v, input int r, input int c0, input int c1, input int c2, input int c3);
    vecs[v].e[r*4+0] = 16'(c0);
    vecs[v].e[r*4+1] = 16'(c1);
    vecs[v].e[r*4+2] = 16'(c2);
    vecs[v].e[r*4+3] = 16'(c3);
  endtask

  // Accepts one block and returns the number of edges until out_valid is seen.
  task automatic run_a(input logic mode, input logic [15:0][15:0] x, output int lat);
    for (int j = 0; j < 16; j++) a_X[j*IN_W +: IN_W] = x[j][IN_W-1:0];
    a_mode  = mode;
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    a_mode  = ~mode;
    lat = 0;
    while (!a_ovalid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_a();
    a_oready = 1'b1;
    @(posedge clk); #1;
    a_oready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int bad;
    int nz;
    a_valid = 0; a_mode = 0; a_X = '0; a_oready = 0;
    b_valid = 0; b_mode = 0; b_X = '0; b_oready = 0;
    rst = 1'b1;

    fill(0, 1'b0, 1, -1, 0);      vecs[0].e[0] = 16'(16);
    fill(1, 1'b0, 0, 0, 1);
    set_row(1, 0, 1, 2, 1, 1);    set_row(1, 1, 2, 4, 2, 2);
    set_row(1, 2, 1, 2, 1, 1);    set_row(1, 3, 1, 2, 1, 1);
    fill(2, 1'b0, -256, -1, 0);   vecs[2].e[0] = 16'(-4096);
    fill(3, 1'b0, 0, 6, 1);
    set_row(3, 0, 1, -1, -1, 2);  set_row(3, 1, 1, -1, -1, 2);
    set_row(3, 2, -1, 1, 1, -2);  set_row(3, 3, -2, 2, 2, -4);
    fill(4, 1'b1, 0, 0, 64);
    for (int j = 0; j < 16; j++) vecs[4].e[j] = 16'(64);
    fill(5, 1'b1, 0, 5, 4);
    set_row(5, 0, 4, 2, -2, -4);  set_row(5, 1, 2, 1, -1, -2);
    set_row(5, 2, -2, -1, 1, 2);  set_row(5, 3, -4, -2, 2, 4);
    fill(6, 1'b1, 0, 5, 3);
    set_row(6, 0, 3, 1, -1, -3);  set_row(6, 1, 1, 0, 0, -1);
    set_row(6, 2, -1, -1, 1, 1);  set_row(6, 3, -3, -2, 2, 3);

    repeat (3) @(posedge clk);
    #1;
    nz = 0;
    for (int j = 0; j < 16; j++) if (a_t(j) != 0) nz++;
    check("rst_in_ready", int'(a_ready), 1);
    check("rst_out_valid", int'(a_ovalid), 0);
    check("rst_out_busy", int'(a_busy), 0);
    check("rst_out_T_nonzero", nz, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < NV; v++) begin
      run_a(vecs[v].mode, vecs[v].x, lat);
      check($sformatf("v%0d_latency", v), lat, 32);
      for (int j = 0; j < 16; j++)
        check($sformatf("v%0d_T%0d", v, j), a_t(j), int'($signed(vecs[v].e[j])));
      release_a();
      check($sformatf("v%0d_idle_ready", v), int'(a_ready), 1);
      $display("[TB] vector %0d mode=%0d latency=%0d T00=%0d", v, vecs[v].mode, lat, a_t(0));
    end

    for (int j = 0; j < 16; j++) b_X[j*IN_W +: IN_W] = 9'sd255;
    b_mode = 1'b0;
    b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    lat = 0;
    while (!b_ovalid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w12_latency", lat, 32);
`ifdef TRANSFORM4X4_SATURATE_EN
    check("w12_T00", b_t(0), 2047);
`else
    check("w12_T00", b_t(0), -16);
`endif
    nz = 0;
    for (int j = 1; j < 16; j++) if (b_t(j) != 0) nz++;
    check("w12_rest_nonzero", nz, 0);
    $display("[TB] width12 block latency=%0d T00=%0d", lat, b_t(0));
    b_oready = 1'b1;
    @(posedge clk); #1;
    b_oready = 1'b0;

    run_a(vecs[0].mode, vecs[0].x, lat);
    check("bp_latency", lat, 32);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      a_valid = c[0];
      a_mode  = 1'b1;
      a_X     = {16{9'(c + 3)}};
      @(posedge clk); #1;
      if (!a_ovalid || a_ready || a_t(0) != 16 || a_t(5) != 0) bad++;
    end
    a_valid = 1'b0;
    check("bp_hold_bad_cycles", bad, 0);
    release_a();
    check("bp_out_valid_drop", int'(a_ovalid), 0);
    check("bp_in_ready", int'(a_ready), 1);
    check("bp_T00_kept", a_t(0), 16);
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_queue_busy", int'(a_busy), 0);
    check("bp_no_queue_ready", int'(a_ready), 1);
    $display("[TB] backpressure sequence bad_cycles=%0d", bad);

    for (int j = 0; j < 16; j++) a_X[j*IN_W +: IN_W] = vecs[4].x[j][IN_W-1:0];
    a_mode  = 1'b1;
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    check("abort_busy_s1", int'(a_busy), 1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    nz = 0;
    for (int j = 0; j < 16; j++) if (a_t(j) != 0) nz++;
    check("abort_out_valid", int'(a_ovalid), 0);
    check("abort_in_ready", int'(a_ready), 1);
    check("abort_busy", int'(a_busy), 0);
    check("abort_T_nonzero", nz, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_a(1'b0, vecs[1].x, lat);
    check("after_abort_latency", lat, 32);
    for (int j = 0; j < 16; j++)
      check($sformatf("after_abort_T%0d", j), a_t(j), int'($signed(vecs[1].e[j])));
    release_a();
    $display("[TB] reset-abort sequence latency=%0d T11=%0d", lat, a_t(5));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
